pkt_ff_ingress_chk: RTL and testbench

PKT_FF_INGRESS_CHK -- requirements
Module: pkt_ff_ingress_chk

---
 rtl/pkt_ff_ingress_chk.sv | 99 +++++++++
 tb/tb_pkt_ff_ingress_chk.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pkt_ff_ingress_chk.sv
// pkt_ff_ingress_chk: packet-FIFO ingress framing checker with 1-cycle registered output.
// Optional framing/drop statistics counters are enabled by defining PKT_FF_INGRESS_STATS_EN.
module pkt_ff_ingress_chk #(
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic [DATA_W-1:0] in_data,
   input  logic              ff_full,
   output logic              valid,
   output logic              sop,
   output logic              eop,
   output logic              error,
   output logic [DATA_W-1:0] data,
   output logic [15:0]       frm_err_cnt,
   output logic [15:0]       drop_cnt
);
   localparam int CW = $clog2(MAX_BEATS + 1);
   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q;
   logic valid_q, sop_q, eop_q, error_q;
   logic valid_d, sop_d, eop_d, error_d;
   logic start, s_fwd, s_drop, p_fwd, p_abort;
   // A SOP seen outside PKT starts a packet, whether from IDLE or resyncing out of DROP
   assign start   = in_valid & in_sop & (state_q != PKT);
   assign s_fwd   = start & ~ff_full;
   assign s_drop  = start & ff_full;
   assign p_fwd   = in_valid & (state_q == PKT) & ~in_sop & ~ff_full & (cnt_q != CW'(MAX_BEATS));
   assign p_abort = in_valid & (state_q == PKT) & ~p_fwd;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = !in_valid ? state_q :
                in_eop    ? IDLE :
                start     ? (ff_full ? DROP : PKT) :
                (state_q == PKT) ? (p_fwd ? PKT : DROP) : state_q;
      cnt_d   = s_fwd ? CW'(1) : p_fwd ? cnt_q + 1'b1 : cnt_q;
   end
   always_comb begin
      valid_d = s_fwd | p_fwd | p_abort;
      sop_d   = s_fwd;
      eop_d   = (s_fwd | p_fwd) & in_eop;
      error_d = p_abort;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         error_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         error_q <= error_d;
         data_q  <= valid_d ? in_data : data_q;
      end
   end
   assign valid = valid_q;
   assign sop   = sop_q;
   assign eop   = eop_q;
   assign error = error_q;
   assign data  = data_q;
`ifdef PKT_FF_INGRESS_STATS_EN
   logic [15:0] ferr_q, drop_q;
   logic ferr_inc, drop_inc;
   // Framing errors: orphan beats in IDLE and SOPs that cut an open packet short
   assign ferr_inc = (in_valid & ~in_sop & (state_q == IDLE)) | (p_abort & in_sop);
   assign drop_inc = s_drop | p_abort;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ferr_q <= '0;
         drop_q <= '0;
      end else begin
         ferr_q <= (ferr_inc && ferr_q != 16'hFFFF) ? ferr_q + 16'd1 : ferr_q;
         drop_q <= (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      end
   end
   assign frm_err_cnt = ferr_q;
   assign drop_cnt    = drop_q;
`else
   assign frm_err_cnt = 16'd0;
   assign drop_cnt    = 16'd0;
`endif
endmodule

// File: tb/tb_pkt_ff_ingress_chk.sv
// tb_pkt_ff_ingress_chk: directed vector table, reset sequence and randomized run against a packet-level model.
module tb_pkt_ff_ingress_chk;
   localparam int DW = 16;
   localparam int MB = 4;
   logic clk = 1'b0, rst_n = 1'b1;
   logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, ff_full = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic valid, sop, eop, error;
   logic [DW-1:0] data;
   logic [15:0] frm_err_cnt, drop_cnt;
   int tests = 0, fails = 0;
   pkt_ff_ingress_chk #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_data(in_data), .ff_full(ff_full), .valid(valid), .sop(sop), .eop(eop),
      .error(error), .data(data), .frm_err_cnt(frm_err_cnt), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic v, s, e, f;
      logic [DW-1:0] d;
      logic [3:0] x;
   } vec_t;
   vec_t tbl[$];
   function automatic vec_t mk(logic v, logic s, logic e, logic f, logic [DW-1:0] d, logic [3:0] x);
      vec_t r;
      r.v = v; r.s = s; r.e = e; r.f = f; r.d = d; r.x = x;
      return r;
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic drive(logic v, logic s, logic e, logic f, logic [DW-1:0] d);
      in_valid = v; in_sop = s; in_eop = e; ff_full = f; in_data = d;
      @(posedge clk);
      #1;
   endtask
   function automatic int sat(int x);
      return (x >= 65535) ? 65535 : x + 1;
   endfunction
   function automatic int stat(int x);
`ifdef PKT_FF_INGRESS_STATS_EN
      return x;
`else
      return 0 * x;
`endif
   endfunction
   bit m_open, m_skip;
   int m_beats, m_ferr, m_drop;
   logic mv, ms, me, mr;
   logic [DW-1:0] md;
   task automatic model_reset();
      m_open = 0; m_skip = 0; m_beats = 0; m_ferr = 0; m_drop = 0;
   endtask
   task automatic model_step();
      mv = 0; ms = 0; me = 0; mr = 0; md = in_data;
      if (in_valid) begin
         if (m_open) begin
            if (in_sop || ff_full || m_beats == MB) begin
               mv = 1; mr = 1;
               m_drop = sat(m_drop);
               if (in_sop) m_ferr = sat(m_ferr);
               m_open = 0; m_skip = !in_eop;
            end else begin
               mv = 1; me = in_eop; m_beats++; m_open = !in_eop;
            end
         end else if (in_sop) begin
            m_skip = 0;
            if (ff_full) begin
               m_drop = sat(m_drop); m_skip = !in_eop;
            end else begin
               mv = 1; ms = 1; me = in_eop; m_beats = 1; m_open = !in_eop;
            end
         end else if (m_skip) m_skip = !in_eop;
         else m_ferr = sat(m_ferr);
      end
   endtask
   initial begin
      bit out_open;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_outs", {valid, sop, eop, error, data}, '0);
      chk("reset_cnts", {frm_err_cnt, drop_cnt}, '0);
      #9 rst_n = 1'b1;
      // {valid,sop,eop,error} expected one cycle after each vector
      tbl.push_back(mk(1,1,0,0,16'd1,4'b1100));
      tbl.push_back(mk(1,0,0,0,16'd2,4'b1000));
      tbl.push_back(mk(1,0,0,0,16'd3,4'b1000));
      tbl.push_back(mk(1,0,1,0,16'd4,4'b1010));
      tbl.push_back(mk(0,0,0,0,16'd0,4'b0000));
      tbl.push_back(mk(1,1,0,0,16'd5,4'b1100));
      tbl.push_back(mk(1,0,0,0,16'd6,4'b1000));
      tbl.push_back(mk(1,1,0,0,16'd7,4'b1001));
      tbl.push_back(mk(1,0,0,0,16'd8,4'b0000));
      tbl.push_back(mk(1,0,1,0,16'd9,4'b0000));
      tbl.push_back(mk(1,1,0,0,16'd11,4'b1100));
      tbl.push_back(mk(1,0,0,0,16'd12,4'b1000));
      tbl.push_back(mk(1,0,0,0,16'd13,4'b1000));
      tbl.push_back(mk(1,0,0,0,16'd14,4'b1000));
      tbl.push_back(mk(1,0,0,0,16'd15,4'b1001));
      tbl.push_back(mk(1,0,1,0,16'd16,4'b0000));
      tbl.push_back(mk(1,1,0,0,16'd20,4'b1100));
      tbl.push_back(mk(1,0,0,0,16'd21,4'b1000));
      tbl.push_back(mk(1,0,0,1,16'd22,4'b1001));
      tbl.push_back(mk(1,0,0,1,16'd23,4'b0000));
      tbl.push_back(mk(1,0,1,0,16'd24,4'b0000));
      tbl.push_back(mk(1,1,0,0,16'd25,4'b1100));
      tbl.push_back(mk(1,0,1,0,16'd26,4'b1010));
      tbl.push_back(mk(1,0,1,0,16'd30,4'b0000));
      tbl.push_back(mk(1,1,1,0,16'd31,4'b1110));
      tbl.push_back(mk(1,1,0,1,16'd40,4'b0000));
      tbl.push_back(mk(1,1,0,0,16'd41,4'b1100));
      tbl.push_back(mk(1,0,1,0,16'd42,4'b1010));
      tbl.push_back(mk(0,0,0,0,16'd43,4'b0000));
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].d);
         chk($sformatf("vec%0d", i), {valid, sop, eop, error, (valid ? data : 16'd0)},
             {tbl[i].x, (tbl[i].x[3] ? tbl[i].d : 16'd0)});
      end
      chk("frm_err_cnt", {48'd0, frm_err_cnt}, 64'(stat(2)));
      chk("drop_cnt", {48'd0, drop_cnt}, 64'(stat(4)));
      drive(1,1,0,0,16'd50);
      drive(1,0,0,0,16'd51);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("midpkt_reset", {valid, sop, eop, error, data, frm_err_cnt, drop_cnt}, '0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      drive(1,1,1,0,16'd52);
      chk("post_reset_pkt", {valid, sop, eop, error, data}, {4'b1110, 16'd52});
      drive(0,0,0,0,16'd0);
      chk("post_reset_idle", {valid, sop, eop, error}, 4'b0000);
      model_reset();
      out_open = 0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_sop   = ($urandom_range(0, 3) == 0);
         in_eop   = ($urandom_range(0, 2) == 0);
         ff_full  = ($urandom_range(0, 6) == 0);
         in_data  = DW'($urandom);
         model_step();
         @(posedge clk);
         #1;
         chk("rand_beat", {valid, sop, eop, error, (valid ? data : 16'd0)},
             {mv, ms, me, mr, (mv ? md : 16'd0)});
         chk("rand_cnt", {frm_err_cnt, drop_cnt}, {16'(stat(m_ferr)), 16'(stat(m_drop))});
         chk("rand_framing", {valid & sop & (error | out_open)}, 0);
         if (valid && (eop || error)) out_open = 0;
         else if (valid && sop) out_open = 1;
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
